// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared types for the core/debug memory-port arbiter.
//   arb_state_e : arbiter FSM states
//   ARB_CORE/ARB_DBG : requester indices used for grants and last_grant
//   arb_req_t   : one requester's bus request (also the latched transfer)
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_LOCK_C = 2'd1,
    ARB_LOCK_D = 2'd2
  } arb_state_e;

  localparam logic ARB_CORE = 1'b0;
  localparam logic ARB_DBG  = 1'b1;

  // Field widths of the request record; raise these if the arbiter is
  // instantiated with wider address or data buses.
  localparam int unsigned ARB_ADDR_W = 32;
  localparam int unsigned ARB_DATA_W = 32;
  localparam int unsigned ARB_BE_W   = ARB_DATA_W / 8;

  typedef struct packed {
    logic                  read;
    logic                  write;
    logic [ARB_ADDR_W-1:0] addr;
    logic [ARB_DATA_W-1:0] wdata;
    logic [ARB_BE_W-1:0]   be;
  } arb_req_t;

endpackage

// File: rtl/mem_arbiter_pick.sv
// arb_pick: combinational 2-way winner selection.
//   active_i     : per-requester active bits (index ARB_CORE / ARB_DBG)
//   last_grant_i : requester granted most recently
//   grant_o      : winning requester index
//   valid_o      : at least one requester is active
// DBG_PRIORITY=1 makes debug win every tie; 0 gives the tie to the
// requester that was not granted last.
module arb_pick
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned DBG_PRIORITY = 0
) (
  input  logic [1:0] active_i,
  input  logic       last_grant_i,
  output logic       grant_o,
  output logic       valid_o
);

  always_comb begin
    valid_o = |active_i;
    grant_o = ARB_CORE;
    if (active_i == 2'b11) begin
      grant_o = (DBG_PRIORITY != 0) ? ARB_DBG : ~last_grant_i;
    end else if (active_i[ARB_DBG]) begin
      grant_o = ARB_DBG;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between the core (c_*) and the debug
// system-bus master (d_*). Each side holds read/write until complete_* or err.
//   clk, rst_n             : clock, synchronous active-low reset
//   c_*/d_* inputs         : read, write, addr, wdata, be (request, held)
//   c_*/d_* outputs        : rdata, complete_read, complete_write, err pulses
//   m_* outputs            : read, write, addr, wdata, be to memory
//   m_rdata, m_complete_*  : memory response
// A free port forwards the winner combinationally (zero latency); a transfer
// not completed in its first cycle is latched and replayed until the memory
// completes it or the wait counter reaches TIMEOUT.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DBG_PRIORITY = 0,
  parameter int unsigned TIMEOUT      = 256
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    c_read,
  input  logic                    c_write,
  input  logic [ADDR_WIDTH-1:0]   c_addr,
  input  logic [DATA_WIDTH-1:0]   c_wdata,
  input  logic [DATA_WIDTH/8-1:0] c_be,
  output logic [DATA_WIDTH-1:0]   c_rdata,
  output logic                    c_complete_read,
  output logic                    c_complete_write,
  output logic                    c_err,
  input  logic                    d_read,
  input  logic                    d_write,
  input  logic [ADDR_WIDTH-1:0]   d_addr,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  input  logic [DATA_WIDTH/8-1:0] d_be,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  output logic                    d_complete_read,
  output logic                    d_complete_write,
  output logic                    d_err,
  output logic                    m_read,
  output logic                    m_write,
  output logic [ADDR_WIDTH-1:0]   m_addr,
  output logic [DATA_WIDTH-1:0]   m_wdata,
  output logic [DATA_WIDTH/8-1:0] m_be,
  input  logic [DATA_WIDTH-1:0]   m_rdata,
  input  logic                    m_complete_read,
  input  logic                    m_complete_write
);

  localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned CNT_W    = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

  arb_state_e       state_q, state_d;
  logic             last_grant_q, last_grant_d;
  arb_req_t         lat_q, lat_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  arb_req_t c_req, d_req, win_req, cur;
  logic     win, win_valid;
  logic     owner, done_rd, done_wr, err;

  always_comb begin
    c_req = '{read: c_read, write: c_write, addr: ARB_ADDR_W'(c_addr),
              wdata: ARB_DATA_W'(c_wdata), be: ARB_BE_W'(c_be)};
    d_req = '{read: d_read, write: d_write, addr: ARB_ADDR_W'(d_addr),
              wdata: ARB_DATA_W'(d_wdata), be: ARB_BE_W'(d_be)};
    win_req = (win == ARB_DBG) ? d_req : c_req;
  end

  arb_pick #(
    .DBG_PRIORITY(DBG_PRIORITY)
  ) u_pick (
    .active_i    ({d_read | d_write, c_read | c_write}),
    .last_grant_i(last_grant_q),
    .grant_o     (win),
    .valid_o     (win_valid)
  );

  always_comb begin
    state_d          = state_q;
    last_grant_d     = last_grant_q;
    lat_d            = lat_q;
    cnt_d            = cnt_q;
    cur              = '0;
    owner            = ARB_CORE;
    done_rd          = 1'b0;
    done_wr          = 1'b0;
    err              = 1'b0;
    m_read           = 1'b0;
    m_write          = 1'b0;
    m_addr           = '0;
    m_wdata          = '0;
    m_be             = '0;
    c_rdata          = '0;
    c_complete_read  = 1'b0;
    c_complete_write = 1'b0;
    c_err            = 1'b0;
    d_rdata          = '0;
    d_complete_read  = 1'b0;
    d_complete_write = 1'b0;
    d_err            = 1'b0;
    // Outputs are held at zero for the whole reset, not just after the edge.
    if (rst_n) begin
      case (state_q)
        ARB_IDLE: begin
          if (win_valid) begin
            cur          = win_req;
            cur.read     = win_req.read & ~win_req.write;
            owner        = win;
            last_grant_d = win;
            done_rd      = cur.read & m_complete_read;
            done_wr      = cur.write & m_complete_write;
            if (!(done_rd || done_wr)) begin
              state_d = (win == ARB_DBG) ? ARB_LOCK_D : ARB_LOCK_C;
              lat_d   = cur;
              cnt_d   = CNT_W'(1);
            end
          end
        end
        ARB_LOCK_C, ARB_LOCK_D: begin
          cur     = lat_q;
          owner   = (state_q == ARB_LOCK_D) ? ARB_DBG : ARB_CORE;
          done_rd = cur.read & m_complete_read;
          done_wr = cur.write & m_complete_write;
          if (done_rd || done_wr) begin
            state_d = ARB_IDLE;
            cnt_d   = '0;
          end else if (TIMEOUT != 0 && cnt_q == CNT_W'(TIMEOUT)) begin
            err     = 1'b1;
            state_d = ARB_IDLE;
            cnt_d   = '0;
          end else if (TIMEOUT != 0) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = ARB_IDLE;
      endcase

      m_read  = cur.read;
      m_write = cur.write;
      m_addr  = ADDR_WIDTH'(cur.addr);
      m_wdata = DATA_WIDTH'(cur.wdata);
      m_be    = BE_WIDTH'(cur.be);

      c_complete_read  = done_rd & (owner == ARB_CORE);
      c_complete_write = done_wr & (owner == ARB_CORE);
      c_err            = err & (owner == ARB_CORE);
      c_rdata          = c_complete_read ? m_rdata : '0;
      d_complete_read  = done_rd & (owner == ARB_DBG);
      d_complete_write = done_wr & (owner == ARB_DBG);
      d_err            = err & (owner == ARB_DBG);
      d_rdata          = d_complete_read ? m_rdata : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ARB_IDLE;
      last_grant_q <= ARB_DBG;
      lat_q        <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      lat_q        <= lat_d;
      cnt_q        <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: drives two arbiters with shared stimulus; index 0 is
// round-robin, index 1 gives debug priority. Both use TIMEOUT=4.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        c_read, c_write, d_read, d_write;
  logic [31:0] c_addr, c_wdata, d_addr, d_wdata, m_rdata;
  logic [3:0]  c_be, d_be;
  logic        m_complete_read, m_complete_write;

  logic [31:0] c_rdata [2];
  logic [31:0] d_rdata [2];
  logic [31:0] m_addr  [2];
  logic [31:0] m_wdata [2];
  logic [3:0]  m_be    [2];
  logic        c_cr [2], c_cw [2], c_err [2];
  logic        d_cr [2], d_cw [2], d_err [2];
  logic        m_rd [2], m_wr [2];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_arbiter #(
      .ADDR_WIDTH  (32),
      .DATA_WIDTH  (32),
      .DBG_PRIORITY(g),
      .TIMEOUT     (4)
    ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .c_read          (c_read),
      .c_write         (c_write),
      .c_addr          (c_addr),
      .c_wdata         (c_wdata),
      .c_be            (c_be),
      .c_rdata         (c_rdata[g]),
      .c_complete_read (c_cr[g]),
      .c_complete_write(c_cw[g]),
      .c_err           (c_err[g]),
      .d_read          (d_read),
      .d_write         (d_write),
      .d_addr          (d_addr),
      .d_wdata         (d_wdata),
      .d_be            (d_be),
      .d_rdata         (d_rdata[g]),
      .d_complete_read (d_cr[g]),
      .d_complete_write(d_cw[g]),
      .d_err           (d_err[g]),
      .m_read          (m_rd[g]),
      .m_write         (m_wr[g]),
      .m_addr          (m_addr[g]),
      .m_wdata         (m_wdata[g]),
      .m_be            (m_be[g]),
      .m_rdata         (m_rdata),
      .m_complete_read (m_complete_read),
      .m_complete_write(m_complete_write)
    );
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle_inputs();
    c_read = 1'b0; c_write = 1'b0; c_addr = '0; c_wdata = '0; c_be = '0;
    d_read = 1'b0; d_write = 1'b0; d_addr = '0; d_wdata = '0; d_be = '0;
    m_rdata = '0; m_complete_read = 1'b0; m_complete_write = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    c_read = 1'b1; c_addr = 32'h44;
    d_write = 1'b1; d_addr = 32'h88;
    cyc();
    settle();
    tests++;
    if (g_dut[0].dut.state_q !== ARB_IDLE) begin
      fails++; $display("FAIL reset_state: got %0d expected %0d", g_dut[0].dut.state_q, ARB_IDLE);
    end
    tests++;
    if (g_dut[0].dut.last_grant_q !== 1'b1) begin
      fails++; $display("FAIL reset_last_grant: got %b expected 1", g_dut[0].dut.last_grant_q);
    end
    tests++;
    if ({m_rd[0], m_wr[0], m_addr[0], c_cr[0], d_cw[0], c_err[0], d_err[0]} !== '0) begin
      fails++; $display("FAIL reset_outputs: rd=%b wr=%b addr=%h expected all 0", m_rd[0], m_wr[0], m_addr[0]);
    end
    rst_n = 1'b1;
    settle();
    tests++;
    if ({m_rd[0], m_wr[0], m_addr[0]} !== {1'b1, 1'b0, 32'h44}) begin
      fails++; $display("FAIL first_tie_core: rd=%b wr=%b addr=%h expected 1 0 00000044", m_rd[0], m_wr[0], m_addr[0]);
    end
    tests++;
    if ({m_rd[1], m_wr[1], m_addr[1]} !== {1'b0, 1'b1, 32'h88}) begin
      fails++; $display("FAIL first_tie_dbgpri: rd=%b wr=%b addr=%h expected 0 1 00000088", m_rd[1], m_wr[1], m_addr[1]);
    end
    do_reset();
  endtask

  task automatic test_same_cycle_read();
    do_reset();
    c_read = 1'b1; c_addr = 32'h100;
    m_complete_read = 1'b1; m_rdata = 32'hDEADBEEF;
    settle();
    tests++;
    if ({m_rd[0], m_addr[0]} !== {1'b1, 32'h100}) begin
      fails++; $display("FAIL samecyc_bus: rd=%b addr=%h expected 1 00000100", m_rd[0], m_addr[0]);
    end
    tests++;
    if ({c_cr[0], c_rdata[0]} !== {1'b1, 32'hDEADBEEF}) begin
      fails++; $display("FAIL samecyc_resp: cr=%b rdata=%h expected 1 deadbeef", c_cr[0], c_rdata[0]);
    end
    cyc();
    idle_inputs();
    settle();
    tests++;
    if (g_dut[0].dut.state_q !== ARB_IDLE) begin
      fails++; $display("FAIL samecyc_idle: state=%0d expected %0d", g_dut[0].dut.state_q, ARB_IDLE);
    end
  endtask

  task automatic test_locked_write();
    do_reset();
    c_write = 1'b1; c_addr = 32'h200; c_wdata = 32'h12345678; c_be = 4'hF;
    m_rdata = 32'hCAFEF00D;
    for (int k = 0; k < 4; k++) begin
      if (k == 1) begin
        c_addr = 32'hBAD0; c_wdata = 32'h0; c_be = 4'h1;
        m_complete_read = 1'b1;
      end else begin
        m_complete_read = 1'b0;
      end
      m_complete_write = (k == 3);
      settle();
      tests++;
      if ({m_wr[0], m_rd[0], m_addr[0], m_wdata[0], m_be[0]} !== {1'b1, 1'b0, 32'h200, 32'h12345678, 4'hF}) begin
        fails++; $display("FAIL lockwr_bus[%0d]: wr=%b rd=%b addr=%h wdata=%h be=%h expected 1 0 200 12345678 f",
                          k, m_wr[0], m_rd[0], m_addr[0], m_wdata[0], m_be[0]);
      end
      tests++;
      if ({c_cw[0], c_cr[0], c_rdata[0]} !== {(k == 3), 1'b0, 32'h0}) begin
        fails++; $display("FAIL lockwr_resp[%0d]: cw=%b cr=%b rdata=%h expected %b 0 0", k, c_cw[0], c_cr[0], c_rdata[0], (k == 3));
      end
      cyc();
    end
    idle_inputs();
    settle();
    tests++;
    if ({c_cw[0], m_wr[0], g_dut[0].dut.state_q} !== {1'b0, 1'b0, ARB_IDLE}) begin
      fails++; $display("FAIL lockwr_after: cw=%b wr=%b state=%0d expected 0 0 0", c_cw[0], m_wr[0], g_dut[0].dut.state_q);
    end
  endtask

  task automatic test_round_robin();
    logic [31:0] rd;
    do_reset();
    c_read = 1'b1; c_addr = 32'h1000;
    d_read = 1'b1; d_addr = 32'h2000;
    for (int k = 0; k < 8; k++) begin
      m_complete_read = 1'b0;
      settle();
      tests++;
      if ({m_rd[0], m_addr[0]} !== {1'b1, (k % 2 == 1) ? 32'h2000 : 32'h1000}) begin
        fails++; $display("FAIL rr_grant[%0d]: rd=%b addr=%h expected %s", k, m_rd[0], m_addr[0], (k % 2 == 1) ? "debug" : "core");
      end
      cyc();
      rd = $urandom;
      m_rdata = rd;
      m_complete_read = 1'b1;
      settle();
      tests++;
      if ({c_cr[0], c_rdata[0], d_cr[0], d_rdata[0]} !==
          ((k % 2 == 1) ? {1'b0, 32'h0, 1'b1, rd} : {1'b1, rd, 1'b0, 32'h0})) begin
        fails++; $display("FAIL rr_complete[%0d]: c=%b/%h d=%b/%h data %h", k, c_cr[0], c_rdata[0], d_cr[0], d_rdata[0], rd);
      end
      cyc();
    end
    idle_inputs();
  endtask

  task automatic test_dbg_priority();
    do_reset();
    c_read = 1'b1; c_addr = 32'h1000;
    d_read = 1'b1; d_addr = 32'h2000;
    for (int k = 0; k < 3; k++) begin
      m_complete_read = 1'b0;
      settle();
      tests++;
      if ({m_rd[1], m_addr[1]} !== {1'b1, 32'h2000}) begin
        fails++; $display("FAIL pri_grant[%0d]: rd=%b addr=%h expected 1 00002000", k, m_rd[1], m_addr[1]);
      end
      cyc();
      m_complete_read = 1'b1; m_rdata = 32'h5A5A0000 + k;
      settle();
      tests++;
      if ({d_cr[1], c_cr[1]} !== 2'b10) begin
        fails++; $display("FAIL pri_complete[%0d]: d_cr=%b c_cr=%b expected 1 0", k, d_cr[1], c_cr[1]);
      end
      cyc();
    end
    d_read = 1'b0;
    m_complete_read = 1'b1; m_rdata = 32'h0BADF00D;
    settle();
    tests++;
    if ({m_addr[1], c_cr[1], c_rdata[1]} !== {32'h1000, 1'b1, 32'h0BADF00D}) begin
      fails++; $display("FAIL pri_core_alone: addr=%h cr=%b rdata=%h expected 1000 1 0badf00d", m_addr[1], c_cr[1], c_rdata[1]);
    end
    cyc();
    idle_inputs();
  endtask

  task automatic test_timeout();
    do_reset();
    d_read = 1'b1; d_addr = 32'h300; m_rdata = 32'hA5A5A5A5;
    for (int k = 0; k <= 4; k++) begin
      settle();
      tests++;
      if ({m_rd[0], m_addr[0], d_err[0], d_cr[0], d_rdata[0]} !== {1'b1, 32'h300, (k == 4), 1'b0, 32'h0}) begin
        fails++; $display("FAIL timeout_cycle[%0d]: rd=%b addr=%h err=%b cr=%b rdata=%h expected err=%b", k,
                          m_rd[0], m_addr[0], d_err[0], d_cr[0], d_rdata[0], (k == 4));
      end
      cyc();
    end
    d_read = 1'b0;
    settle();
    tests++;
    if ({m_rd[0], d_err[0]} !== 2'b00) begin
      fails++; $display("FAIL timeout_after: rd=%b err=%b expected 0 0", m_rd[0], d_err[0]);
    end
    m_complete_read = 1'b1;
    settle();
    tests++;
    if ({c_cr[0], d_cr[0], c_rdata[0], d_rdata[0]} !== '0) begin
      fails++; $display("FAIL late_complete: c_cr=%b d_cr=%b c_rdata=%h d_rdata=%h expected 0", c_cr[0], d_cr[0], c_rdata[0], d_rdata[0]);
    end
    cyc();
    c_read = 1'b1; c_addr = 32'h400; m_rdata = 32'h11223344;
    settle();
    tests++;
    if ({m_addr[0], c_cr[0], c_rdata[0]} !== {32'h400, 1'b1, 32'h11223344}) begin
      fails++; $display("FAIL timeout_core_next: addr=%h cr=%b rdata=%h expected 400 1 11223344", m_addr[0], c_cr[0], c_rdata[0]);
    end
    cyc();
    idle_inputs();
  endtask

  task automatic test_reset_mid_lock();
    do_reset();
    c_read = 1'b1; c_addr = 32'h500;
    cyc();
    settle();
    tests++;
    if (g_dut[0].dut.state_q !== ARB_LOCK_C) begin
      fails++; $display("FAIL midrst_locked: state=%0d expected %0d", g_dut[0].dut.state_q, ARB_LOCK_C);
    end
    rst_n = 1'b0;
    cyc();
    settle();
    tests++;
    if ({g_dut[0].dut.state_q, g_dut[0].dut.last_grant_q} !== {ARB_IDLE, 1'b1}) begin
      fails++; $display("FAIL midrst_state: state=%0d last=%b expected 0 1", g_dut[0].dut.state_q, g_dut[0].dut.last_grant_q);
    end
    tests++;
    if ({m_rd[0], m_wr[0], m_addr[0], c_cr[0], c_cw[0], c_err[0], c_rdata[0]} !== '0) begin
      fails++; $display("FAIL midrst_outputs: rd=%b addr=%h cr=%b expected 0", m_rd[0], m_addr[0], c_cr[0]);
    end
    idle_inputs();
    rst_n = 1'b1;
    cyc();
  endtask

  // Transaction-level reference: each requester keeps one pending request;
  // the bus holds at most one transfer, aged in cycles since its grant, and
  // the memory answers after a randomly chosen latency (5 never arrives).
  task automatic test_random();
    bit          pr [2];
    bit          pw [2];
    logic [31:0] pa [2];
    logic [31:0] pd [2];
    logic [3:0]  pb [2];
    int          owner, last, age, lat, cur, win;
    bit          tw, lw, busy, done, err, a0, a1;
    logic [31:0] ta, td, la, ld, rd;
    logic [3:0]  tbe, lbe;
    logic [5:0]  eresp;
    do_reset();
    owner = -1; last = 1; age = 0; lat = 0;
    lw = 1'b0; la = '0; ld = '0; lbe = '0; tw = 1'b0; ta = '0; td = '0; tbe = '0;
    for (int r = 0; r < 2; r++) begin
      pr[r] = 1'b0; pw[r] = 1'b0; pa[r] = '0; pd[r] = '0; pb[r] = '0;
    end
    for (int n = 0; n < 400; n++) begin
      for (int r = 0; r < 2; r++) begin
        if (!pr[r] && !pw[r] && $urandom_range(0, 1) == 1) begin
          pw[r] = 1'($urandom_range(0, 1));
          pr[r] = !pw[r] || ($urandom_range(0, 3) == 0);
          pa[r] = $urandom; pd[r] = $urandom; pb[r] = 4'($urandom_range(0, 15));
        end
      end
      c_read = pr[0]; c_write = pw[0]; c_addr = pa[0]; c_wdata = pd[0]; c_be = pb[0];
      d_read = pr[1]; d_write = pw[1]; d_addr = pa[1]; d_wdata = pd[1]; d_be = pb[1];
      win = -1; cur = -1;
      if (owner < 0) begin
        a0 = pr[0] | pw[0];
        a1 = pr[1] | pw[1];
        if (a0 && a1) win = (last == 0) ? 1 : 0;
        else if (a0) win = 0;
        else if (a1) win = 1;
        if (win >= 0) begin
          cur = win; tw = pw[win]; ta = pa[win]; td = pd[win]; tbe = pb[win];
          age = 0; lat = $urandom_range(0, 5);
        end
      end else begin
        cur = owner; tw = lw; ta = la; td = ld; tbe = lbe;
      end
      busy = (cur >= 0);
      done = busy && (age == lat);
      err  = busy && !done && (age == 4);
      rd = $urandom;
      m_rdata = rd;
      if (busy && !tw) m_complete_read = done;
      else m_complete_read = 1'($urandom_range(0, 1));
      if (busy && tw) m_complete_write = done;
      else m_complete_write = 1'($urandom_range(0, 1));
      eresp = {cur == 0 && done && !tw, cur == 0 && done && tw, cur == 0 && err,
               cur == 1 && done && !tw, cur == 1 && done && tw, cur == 1 && err};
      settle();
      tests++;
      if ({m_rd[0], m_wr[0]} !== {busy && !tw, busy && tw}) begin
        fails++; $display("FAIL rand_req[%0d]: rd=%b wr=%b expected %b %b", n, m_rd[0], m_wr[0], busy && !tw, busy && tw);
      end
      if (busy) begin
        tests++;
        if ({m_addr[0], m_wdata[0], m_be[0]} !== {ta, td, tbe}) begin
          fails++; $display("FAIL rand_bus[%0d]: addr=%h wdata=%h be=%h expected %h %h %h", n, m_addr[0], m_wdata[0], m_be[0], ta, td, tbe);
        end
      end
      tests++;
      if ({c_cr[0], c_cw[0], c_err[0], d_cr[0], d_cw[0], d_err[0]} !== eresp) begin
        fails++; $display("FAIL rand_resp[%0d]: got %b expected %b", n, {c_cr[0], c_cw[0], c_err[0], d_cr[0], d_cw[0], d_err[0]}, eresp);
      end
      tests++;
      if ({c_rdata[0], d_rdata[0]} !== {eresp[5] ? rd : 32'h0, eresp[2] ? rd : 32'h0}) begin
        fails++; $display("FAIL rand_rdata[%0d]: c=%h d=%h mem=%h", n, c_rdata[0], d_rdata[0], rd);
      end
      if (busy) begin
        if (win >= 0) last = win;
        if (done || err) begin
          pr[cur] = 1'b0; pw[cur] = 1'b0;
          owner = -1;
        end else begin
          if (owner < 0) begin
            owner = cur; lw = tw; la = ta; ld = td; lbe = tbe;
          end
          age++;
        end
      end
      cyc();
    end
    idle_inputs();
    do_reset();
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    cyc();
    test_reset();
    test_same_cycle_read();
    test_locked_write();
    test_round_robin();
    test_dbg_priority();
    test_timeout();
    test_reset_mid_lock();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single memory port between two requesters: the core's multicycle control and datapath (`c_`), and the debug module's system-bus access (`d_`).
- Each requester uses the core's native protocol: hold read/write until complete_read or complete_write. Completion may come in the same cycle as the request or any later cycle.
- Sits between the core/debug and the memory wrapper. Adds zero latency when the port is free, and aborts stalled transfers on timeout.

Parameters:
ADDR_WIDTH, 32, address width
DATA_WIDTH, 32, data width; byte-enable width = DATA_WIDTH/8
DBG_PRIORITY, 0, 1 = debug always wins in IDLE; 0 = round-robin
TIMEOUT, 256, cycles a locked transfer may wait before abort; 0 disables the timeout

Ports (prefix `x` = `c` for core or `d` for debug; one identical port set per requester):
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
x_read  in  1  read request, held until x_complete_read or x_err
x_write  in  1  write request, held until x_complete_write or x_err
x_addr  in  ADDR_WIDTH  byte address
x_wdata  in  DATA_WIDTH  write data
x_be  in  DATA_WIDTH/8  byte enables
x_rdata  out  DATA_WIDTH  read data, valid with x_complete_read
x_complete_read  out  1  read done, one-cycle pulse
x_complete_write  out  1  write done, one-cycle pulse
x_err  out  1  transfer aborted by timeout, one-cycle pulse
m_read  out  1  memory read request
m_write  out  1  memory write request
m_addr  out  ADDR_WIDTH  memory address
m_wdata  out  DATA_WIDTH  memory write data
m_be  out  DATA_WIDTH/8  memory byte enables
m_rdata  in  DATA_WIDTH  memory read data
m_complete_read  in  1  memory read done
m_complete_write  in  1  memory write done

Behaviour:
- States: IDLE, LOCK_C, LOCK_D. Also held:
  - last_grant register (0 = core, 1 = debug);
  - latched request: addr, wdata, be, is_write;
  - wait counter, width $clog2(TIMEOUT+1).
- Reset values:
  - state = IDLE, last_grant = 1 (core wins the first tie), counter = 0;
  - all m_* and x_* outputs = 0.
- IDLE arbitration:
  - A requester is active if read or write is asserted.
  - One active requester wins.
  - Both active: DBG_PRIORITY=1 → debug wins; DBG_PRIORITY=0 → the one not equal to last_grant wins.
- IDLE forwarding:
  - The winner's signals are forwarded combinationally to m_* in the same cycle.
  - If read and write are both asserted, write wins and read is ignored.
- IDLE completion:
  - If the matching m_complete_* is asserted in the same cycle, it is routed to the winner's complete output and m_rdata to its x_rdata.
  - State stays IDLE and last_grant is updated to the winner.
- IDLE without completion:
  - The request is latched and state moves to LOCK_C or LOCK_D; counter = 1.
  - last_grant is updated on lock.
- LOCK_x:
  - m_* is driven from the latch, not the live inputs.
  - The other requester's outputs stay 0; its request stays pending.
- LOCK_x, on the matching m_complete_*:
  - pulse x_complete_*; drive x_rdata = m_rdata for reads;
  - return to IDLE. The next arbitration happens in the following cycle, so there is no same-cycle re-grant.
- LOCK_x, timeout (TIMEOUT≠0 and counter==TIMEOUT without completion):
  - deassert m_*, pulse x_err with x_rdata=0, return to IDLE;
  - a late m_complete_* arriving in IDLE while no transfer is forwarded is ignored.
- Owner drops its request while locked: lock is held until memory completes or timeout; the completion pulse is still issued (harmless).
- x_rdata is 0 whenever x_complete_read is 0.
- m_complete_* of the wrong type (e.g. complete_write during a read) is ignored.
- Reset mid-transfer: immediate return to reset values; memory is reset alongside.

Decomposition:
- Shared package holds:
  - state enum (ARB_IDLE, ARB_LOCK_C, ARB_LOCK_D);
  - requester index constants (ARB_CORE=0, ARB_DBG=1);
  - a request struct {read, write, addr, wdata, be}.
- One sub-module, arb_pick: combinational 2-way picker taking active bits, last_grant and DBG_PRIORITY, returning the winner. It is reusable for a later third requester.

Test Plan:
- Core read of 0x100, memory completes same cycle with 0xDEADBEEF → m_read=1 and m_addr=0x100 that cycle, c_complete_read=1, c_rdata=0xDEADBEEF, state stays IDLE.
- Core write 0x200/0x12345678, be=0xF, memory completes 3 cycles later → m_* stable from latch for 4 cycles, single c_complete_write pulse, then IDLE.
- Round-robin (DBG_PRIORITY=0), both continuously reading, 2-cycle memory → grants alternate core, debug, core, debug; neither waits more than one transfer.
- DBG_PRIORITY=1, both active → debug granted every arbitration. Core is granted only in a cycle where debug is idle.
- TIMEOUT=4, debug read, memory never completes → d_err pulses after exactly 4 locked cycles with d_rdata=0, then m_read=0. A later m_complete_read is ignored and the core proceeds normally.
- rst_n low during LOCK_C → next cycle state IDLE, all outputs 0, last_grant=1.
